// File: rtl/dmux16_stream.sv
// Two-way stream demultiplexer: each upstream word goes to one of two
// independent FIFOs (channel A or B) according to in_sel.

module dmux16_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             push,
  output logic             full,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             rready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    occ;
  logic             pop;

  assign pop    = rvalid & rready;
  assign full   = (occ == CW'(DEPTH));
  assign rvalid = (occ != '0);
  // Gate the head word so an empty FIFO (and the reset state) shows zero.
  assign rdata  = rvalid ? mem[rptr] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr] <= wdata;
  end
endmodule

// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. in_ready looks only at in_sel and registered occupancy, so a same-cycle
// pop never opens room for a same-cycle push; outputs come straight from the
// FIFO registers, with no combinational path from the input side.
module dmux16_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [15:0]      a_count,
  output logic [15:0]      b_count
);
  logic a_full;
  logic b_full;
  logic a_push;
  logic b_push;

  assign in_ready = in_sel ? ~b_full : ~a_full;
  assign a_push   = in_valid & in_ready & ~in_sel;
  assign b_push   = in_valid & in_ready &  in_sel;

  dmux16_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (in_data),
    .push   (a_push),
    .full   (a_full),
    .rdata  (a_data),
    .rvalid (a_valid),
    .rready (a_ready)
  );

  dmux16_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (in_data),
    .push   (b_push),
    .full   (b_full),
    .rdata  (b_data),
    .rvalid (b_valid),
    .rready (b_ready)
  );

  // Accept counters wrap modulo 2^16.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (a_push) a_count <= a_count + 16'd1;
      if (b_push) b_count <= b_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_dmux16_stream.sv
// Directed plus constrained-random bench for dmux16_stream (WIDTH=16, DEPTH=2).

module tb_dmux16_stream;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [15:0]      a_count;
  logic [15:0]      b_count;

  int n_tests;
  int n_fail;

  logic [WIDTH-1:0] exp_a_q[$];
  logic [WIDTH-1:0] exp_b_q[$];

  dmux16_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    in_data  = '0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  task automatic push_word(input logic sel, input logic [WIDTH-1:0] d);
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (sel) exp_b_q.push_back(d);
    else     exp_a_q.push_back(d);
  endtask

  // Scoreboard: compare the visible head of a channel against its queue.
  task automatic expect_head_a(input string tag);
    check({tag, "_a_valid"}, {31'd0, a_valid}, 32'd1);
    if (exp_a_q.size() != 0) check({tag, "_a_data"}, {16'd0, a_data}, {16'd0, exp_a_q.pop_front()});
    else check({tag, "_a_q_empty"}, 32'd1, 32'd0);
  endtask

  task automatic expect_head_b(input string tag);
    check({tag, "_b_valid"}, {31'd0, b_valid}, 32'd1);
    if (exp_b_q.size() != 0) check({tag, "_b_data"}, {16'd0, b_data}, {16'd0, exp_b_q.pop_front()});
    else check({tag, "_b_q_empty"}, 32'd1, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    idle_inputs();
    #2;

    // Reset state
    do_reset();
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    check("rst_a_data",  {16'd0, a_data},  32'd0);
    check("rst_b_data",  {16'd0, b_data},  32'd0);
    check("rst_a_count", {16'd0, a_count}, 32'd0);
    check("rst_b_count", {16'd0, b_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single accept into A appears next cycle
    push_word(1'b0, 16'h1234);
    check("t30_b_valid", {31'd0, b_valid}, 32'd0);
    check("t30_a_count", {16'd0, a_count}, 32'd1);
    a_ready = 1'b1;
    expect_head_a("t30");
    step();
    a_ready = 1'b0;
    check("t30_drained", {31'd0, a_valid}, 32'd0);

    // Fill A, back-pressure on sel=0, readiness follows sel
    push_word(1'b0, 16'hAAAA);
    push_word(1'b0, 16'hBBBB);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'hCCCC;
    #1;
    check("t31_ready_sel0", {31'd0, in_ready}, 32'd0);
    in_sel = 1'b1;
    #1;
    check("t31_ready_sel1", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    a_ready  = 1'b1;
    expect_head_a("t31_first");
    step();
    expect_head_a("t31_second");
    step();
    a_ready = 1'b0;
    check("t31_empty", {31'd0, a_valid}, 32'd0);
    check("t31_a_count", {16'd0, a_count}, 32'd3);
    check("t31_b_count", {16'd0, b_count}, 32'd0);

    // Pop from full A does not allow a same-cycle push
    push_word(1'b0, 16'h1111);
    push_word(1'b0, 16'h2222);
    a_ready  = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h3333;
    #1;
    check("t32_ready_full", {31'd0, in_ready}, 32'd0);
    void'(exp_a_q.pop_front());
    step();
    in_valid = 1'b0;
    a_ready  = 1'b0;
    check("t32_a_count", {16'd0, a_count}, 32'd5);
    check("t32_ready_occ1", {31'd0, in_ready}, 32'd1);
    a_ready = 1'b1;
    expect_head_a("t32");
    step();
    a_ready = 1'b0;
    check("t32_empty", {31'd0, a_valid}, 32'd0);

    // Alternating channels with both consumers ready
    do_reset();
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push_word(k[0] ? 1'b0 : 1'b1, WIDTH'(k));
      if (k[0]) begin
        expect_head_a($sformatf("t33_w%0d", k));
        check($sformatf("t33_w%0d_bv", k), {31'd0, b_valid}, 32'd0);
      end else begin
        expect_head_b($sformatf("t33_w%0d", k));
        check($sformatf("t33_w%0d_av", k), {31'd0, a_valid}, 32'd0);
      end
    end
    step();
    check("t33_a_empty", {31'd0, a_valid}, 32'd0);
    check("t33_b_empty", {31'd0, b_valid}, 32'd0);
    check("t33_a_count", {16'd0, a_count}, 32'd2);
    check("t33_b_count", {16'd0, b_count}, 32'd2);

    // Reset discards buffered words and blocks an accept at the reset edge
    do_reset();
    b_ready = 1'b0;
    a_ready = 1'b0;
    push_word(1'b1, 16'h5A5A);
    push_word(1'b1, 16'hA5A5);
    check("t35_pre_b_valid", {31'd0, b_valid}, 32'd1);
    in_valid = 1'b1;
    in_sel   = 1'b1;
    in_data  = 16'h7777;
    do_reset();
    in_valid = 1'b0;
    check("t35_b_valid", {31'd0, b_valid}, 32'd0);
    check("t35_b_count", {16'd0, b_count}, 32'd0);
    check("t35_b_data",  {16'd0, b_data},  32'd0);
    check("t35_in_ready", {31'd0, in_ready}, 32'd1);
    b_ready = 1'b1;
    step();
    check("t35_no_old", {31'd0, b_valid}, 32'd0);

    // Randomised traffic against a queue model of both FIFOs
    do_reset();
    begin
      logic [15:0] ca;
      logic [15:0] cb;
      logic        exp_rdy;
      logic        acc;
      ca = '0;
      cb = '0;
      for (int i = 0; i < 400; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = WIDTH'($urandom_range(0, 16'hFFFF));
        a_ready  = ($urandom_range(0, 3) != 0);
        b_ready  = ($urandom_range(0, 2) == 0);
        #1;
        exp_rdy = in_sel ? (exp_b_q.size() < DEPTH) : (exp_a_q.size() < DEPTH);
        check("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("rnd_a_valid", {31'd0, a_valid}, {31'd0, exp_a_q.size() != 0});
        check("rnd_b_valid", {31'd0, b_valid}, {31'd0, exp_b_q.size() != 0});
        if (exp_a_q.size() != 0) check("rnd_a_data", {16'd0, a_data}, {16'd0, exp_a_q[0]});
        if (exp_b_q.size() != 0) check("rnd_b_data", {16'd0, b_data}, {16'd0, exp_b_q[0]});
        acc = in_valid & exp_rdy;
        if (a_ready && exp_a_q.size() != 0) void'(exp_a_q.pop_front());
        if (b_ready && exp_b_q.size() != 0) void'(exp_b_q.pop_front());
        if (acc && !in_sel) begin exp_a_q.push_back(in_data); ca++; end
        if (acc &&  in_sel) begin exp_b_q.push_back(in_data); cb++; end
        step();
      end
      in_valid = 1'b0;
      check("rnd_a_count", {16'd0, a_count}, {16'd0, ca});
      check("rnd_b_count", {16'd0, b_count}, {16'd0, cb});
    end

    // a_count wraparound
    do_reset();
    a_ready  = 1'b1;
    b_ready  = 1'b0;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0F0F;
    for (int i = 0; i < 16'hFFFE; i++) step();
    check("t34_fffe", {16'd0, a_count}, 32'h0000FFFE);
    step();
    check("t34_ffff", {16'd0, a_count}, 32'h0000FFFF);
    step();
    check("t34_wrap", {16'd0, a_count}, 32'h00000000);
    check("t34_b_count", {16'd0, b_count}, 32'd0);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
